hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Stall/flush scheduler for the 5-stage pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB).
//  Resolves load-use, taken-branch and data-memory-wait hazards and drives per-stage
//  stall/flush/bubble controls.
//  Also runs the post-reset boot hold and a data-memory wait watchdog.
// PARAMETERS
//  BOOT_CYCLES  4   cycles the front end is held after reset release (0 = none)
//  MEM_TIMEOUT  64  max mem-wait cycles before bus_err (0 = watchdog disabled)
// PORTS
//  clk            in   1   clock; all state on posedge
//  rst_n          in   1   asynchronous, active-low reset
//  id_rs1,id_rs2  in   5   source regs of instr in ID
//  id_re1,id_re2  in   1   ID actually reads rs1/rs2
//  ex_wR          in   5   dest reg of instr in EX
//  ex_is_load     in   1   instr in EX is a load
//  ex_br_taken    in   1   branch/jump in EX redirects PC
//  mem_req        in   1   instr in MEM issues a data-memory access
//  mem_ready      in   1   data memory completes the access this cycle
//  pc_stall       out  1   hold PC
//  if_id_stall    out  1   hold IF_ID
//  id_ex_stall    out  1   hold ID_EX
//  ex_mem_stall   out  1   hold EX_MEM
//  if_id_flush    out  1   load bubble into IF_ID (have_inst=0)
//  id_ex_flush    out  1   load bubble into ID_EX
//  mem_wb_bubble  out  1   force MEM_WB have_inst/rf_we to 0
//  bus_err        out  1   1-cycle pulse on watchdog expiry
// BEHAVIOUR
//  - FSM: BOOT, RUN, MEMWAIT. Reset -> BOOT (RUN if BOOT_CYCLES=0); boot/wait counters = 0.
//  - While rst_n=0, all outputs are 0. Reset mid-operation aborts everything immediately;
//    no pending flush/err survives.
//  - BOOT: pc_stall=if_id_flush=1, all other outputs 0; counter increments each cycle.
//    After BOOT_CYCLES cycles -> RUN.
//  - RUN, hazards evaluated combinationally in the same cycle, priority high->low:
//    1 mem wait: mem_req & ~mem_ready -> pc/if_id/id_ex/ex_mem_stall=1, mem_wb_bubble=1;
//      go to MEMWAIT, wait counter=1.
//    2 taken branch: ex_br_taken -> if_id_flush=id_ex_flush=1, no stalls (zero extra latency).
//    3 load-use: ex_is_load & ex_wR!=0 & ((id_re1&id_rs1==ex_wR)|(id_re2&id_rs2==ex_wR))
//      -> pc_stall=if_id_stall=1, id_ex_flush=1. Exactly one bubble, because the flush
//      removes the load-use condition next cycle.
//  - Branch and load-use in the same cycle: branch wins; the ID instr is squashed, no stall.
//  - MEMWAIT: same outputs as rule 1 every cycle; wait counter increments.
//    mem_ready=1 -> outputs all 0 that cycle (access completes), next state RUN.
//    A branch held in EX is applied in the first RUN cycle after release.
//    mem_req dropping without mem_ready also -> RUN.
//  - Watchdog (MEM_TIMEOUT>0): counter==MEM_TIMEOUT with no ready -> bus_err=1 for one cycle,
//    stalls released, mem_wb_bubble stays 1 that cycle, -> RUN.
//    mem_ready on the expiry cycle wins: no bus_err.
//  - Counter width $clog2(max(BOOT_CYCLES,MEM_TIMEOUT)+1); counters saturate, never wrap.
//  - Stall and flush are never both asserted for the same register.
//    ex_mem_stall=1 implies mem_wb_bubble=1.
// CONFIGURATION
//  HAZARD_PERF_EN defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
//   - stall_cnt: +1 per cycle with pc_stall=1 in RUN/MEMWAIT.
//   - flush_cnt: +1 per cycle with ex_br_taken honoured.
//   - Both wrap modulo 2^32; reset to 0.
//  HAZARD_PERF_EN undefined: no counters and no ports; behaviour otherwise identical.
// TESTING
//  - Reset release, BOOT_CYCLES=4 -> pc_stall=if_id_flush=1 exactly 4 cycles, then all 0.
//  - EX lw x5; ID add x6,x5,x1 (re1=1) -> 1 cycle pc_stall=if_id_stall=id_ex_flush=1,
//    then 0; ex_wR=0 -> no stall.
//  - ex_br_taken=1 with a load-use present -> if_id_flush=id_ex_flush=1, pc_stall=0.
//  - mem_req=1, mem_ready low 3 cycles -> 3 cycles all stalls+bubble, then 0;
//    state back to RUN.
//  - MEM_TIMEOUT=8, mem_ready never -> bus_err one pulse at cycle 8, stalls drop;
//    same with ready at cycle 8 -> no bus_err.
//  - rst_n low during MEMWAIT -> all outputs 0 immediately; BOOT sequence restarts on release.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: boot hold, load-use, taken-branch and
// data-memory-wait hazards plus a memory-wait watchdog. Optional HAZARD_PERF_EN adds perf counters.
module hazard_ctrl #(
  parameter int BOOT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_re1,
  input  logic       id_re2,
  input  logic [4:0] ex_wR,
  input  logic       ex_is_load,
  input  logic       ex_br_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       id_ex_stall,
  output logic       ex_mem_stall,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       mem_wb_bubble,
  output logic       bus_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int CNT_MAX = (BOOT_CYCLES > MEM_TIMEOUT) ? BOOT_CYCLES : MEM_TIMEOUT;
  localparam int CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [CW-1:0] BOOT_LAST = CW'((BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] WDOG_LIM  = CW'(MEM_TIMEOUT);
  localparam bit            WDOG_EN   = (MEM_TIMEOUT > 0);

  localparam logic [1:0] S_BOOT    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_MEMWAIT = 2'd2;
  localparam logic [1:0] S_RESET   = (BOOT_CYCLES > 0) ? S_BOOT : S_RUN;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_stall;
    logic ex_mem_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_bubble;
    logic bus_err;
  } ctrl_t;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] boot_cnt, boot_nxt;
  logic [CW-1:0] wait_cnt, wait_nxt;
  ctrl_t         ctrl_c, ctrl_q;
  logic          load_use;
  logic          mem_wait;

  assign load_use = ex_is_load && (ex_wR != 5'd0) &&
                    ((id_re1 && (id_rs1 == ex_wR)) || (id_re2 && (id_rs2 == ex_wR)));
  assign mem_wait = mem_req && !mem_ready;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    ctrl_c    = '0;
    state_nxt = state;
    boot_nxt  = boot_cnt;
    wait_nxt  = wait_cnt;
    case (state)
      S_BOOT: begin
        ctrl_c.pc_stall    = 1'b1;
        ctrl_c.if_id_flush = 1'b1;
        if (boot_cnt != '1) boot_nxt = boot_cnt + 1'b1;
        if (boot_cnt >= BOOT_LAST) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (mem_wait) begin
          ctrl_c.pc_stall      = 1'b1;
          ctrl_c.if_id_stall   = 1'b1;
          ctrl_c.id_ex_stall   = 1'b1;
          ctrl_c.ex_mem_stall  = 1'b1;
          ctrl_c.mem_wb_bubble = 1'b1;
          state_nxt            = S_MEMWAIT;
          wait_nxt             = CW'(1);
        end else if (ex_br_taken) begin
          // The branch squashes the ID instruction, so any load-use there is moot.
          ctrl_c.if_id_flush = 1'b1;
          ctrl_c.id_ex_flush = 1'b1;
        end else if (load_use) begin
          ctrl_c.pc_stall    = 1'b1;
          ctrl_c.if_id_stall = 1'b1;
          ctrl_c.id_ex_flush = 1'b1;
        end
      end
      S_MEMWAIT: begin
        if (!mem_req || mem_ready) begin
          state_nxt = S_RUN;
        end else if (WDOG_EN && (wait_cnt == WDOG_LIM)) begin
          ctrl_c.bus_err       = 1'b1;
          ctrl_c.mem_wb_bubble = 1'b1;
          state_nxt            = S_RUN;
        end else begin
          ctrl_c.pc_stall      = 1'b1;
          ctrl_c.if_id_stall   = 1'b1;
          ctrl_c.id_ex_stall   = 1'b1;
          ctrl_c.ex_mem_stall  = 1'b1;
          ctrl_c.mem_wb_bubble = 1'b1;
          if (wait_cnt != '1) wait_nxt = wait_cnt + 1'b1;
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RESET;
      boot_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      boot_cnt <= boot_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Outputs are combinational from the state, so they are forced low while reset is held.
  assign ctrl_q        = rst_n ? ctrl_c : '0;
  assign pc_stall      = ctrl_q.pc_stall;
  assign if_id_stall   = ctrl_q.if_id_stall;
  assign id_ex_stall   = ctrl_q.id_ex_stall;
  assign ex_mem_stall  = ctrl_q.ex_mem_stall;
  assign if_id_flush   = ctrl_q.if_id_flush;
  assign id_ex_flush   = ctrl_q.id_ex_flush;
  assign mem_wb_bubble = ctrl_q.mem_wb_bubble;
  assign bus_err       = ctrl_q.bus_err;

`ifdef HAZARD_PERF_EN
  logic stall_evt, flush_evt;

  assign stall_evt = ctrl_c.pc_stall && (state != S_BOOT);
  assign flush_evt = (state == S_RUN) && !mem_wait && ex_br_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_evt) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush_evt) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (BOOT_CYCLES=4, MEM_TIMEOUT=8): the driver queues the
// expected control vector per cycle and a monitor compares it on the falling edge.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_wR = '0;
  logic       id_re1 = 1'b0, id_re2 = 1'b0, ex_is_load = 1'b0, ex_br_taken = 1'b0;
  logic       mem_req = 1'b0, mem_ready = 1'b0;
  logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic       if_id_flush, id_ex_flush, mem_wb_bubble, bus_err;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  hazard_ctrl #(.BOOT_CYCLES(4), .MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_re1(id_re1), .id_re2(id_re2),
    .ex_wR(ex_wR), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_bubble(mem_wb_bubble), .bus_err(bus_err)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Vector order: pc_stall if_id_stall id_ex_stall ex_mem_stall if_id_flush id_ex_flush bubble bus_err
  localparam logic [7:0] ZERO = 8'b0000_0000;
  localparam logic [7:0] BOOT = 8'b1000_1000;
  localparam logic [7:0] MW   = 8'b1111_0010;
  localparam logic [7:0] BR   = 8'b0000_1100;
  localparam logic [7:0] LU   = 8'b1100_0100;
  localparam logic [7:0] TO   = 8'b0000_0011;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] act;

  assign act = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                if_id_flush, id_ex_flush, mem_wb_bubble, bus_err};

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %b expected %b at %0t", e.name, act, e.exp, $time);
        end
      end
    end
  end

  task automatic vec(input string name, input logic [4:0] rs1, input logic re1,
                     input logic [4:0] rs2, input logic re2, input logic [4:0] wr,
                     input logic ld, input logic br, input logic req, input logic rdy,
                     input logic [7:0] exp);
    @(posedge clk);
    #1;
    id_rs1 = rs1; id_re1 = re1; id_rs2 = rs2; id_re2 = re2;
    ex_wR = wr; ex_is_load = ld; ex_br_taken = br;
    mem_req = req; mem_ready = rdy;
    sb.push_back('{name, exp});
  endtask

  task automatic rst_vec(input string name, input logic r, input logic [7:0] exp);
    @(posedge clk);
    #1;
    rst_n = r;
    id_rs1 = '0; id_re1 = 1'b0; id_rs2 = '0; id_re2 = 1'b0;
    ex_wR = '0; ex_is_load = 1'b0; ex_br_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
    sb.push_back('{name, exp});
  endtask

  task automatic idle(input string name, input logic [7:0] exp);
    vec(name, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp);
  endtask

  initial begin : stim
    int budget;
    rst_vec("reset_low", 1'b0, ZERO);
    rst_vec("reset_low", 1'b0, ZERO);
    rst_vec("boot_0", 1'b1, BOOT);
    for (int i = 1; i < 4; i++) idle("boot_n", BOOT);
    idle("boot_done", ZERO);

    // lw x5 in EX, add x6,x5,x1 in ID; flush turns EX into a bubble next cycle.
    vec("lu_rs1",    5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LU);
    vec("lu_bubble", 5'd5, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ZERO);
    vec("lu_rs2",    5'd2, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, LU);
    vec("lu_no_re",  5'd7, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, ZERO);
    vec("lu_x0",     5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, ZERO);
    vec("no_load",   5'd9, 1'b1, 5'd1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, ZERO);

    vec("br_over_lu", 5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, BR);
    vec("br_only",    5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BR);

    for (int i = 0; i < 3; i++)
      vec("mw3_wait", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MW);
    vec("mw3_ready", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, ZERO);
    idle("mw3_run", ZERO);

    // Branch held in EX during a wait is applied only after release.
    vec("mwbr_enter",   5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, MW);
    vec("mwbr_hold",    5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, MW);
    vec("mwbr_ready",   5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, ZERO);
    vec("mwbr_applied", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BR);

    vec("drop_enter", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MW);
    vec("drop_hold",  5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MW);
    idle("drop_req", ZERO);
    vec("drop_run_lu", 5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, LU);
    idle("drop_idle", ZERO);

    for (int i = 0; i < 8; i++)
      vec("wd_wait", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MW);
    vec("wd_expire", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, TO);
    idle("wd_after", ZERO);

    for (int i = 0; i < 8; i++)
      vec("wdr_wait", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MW);
    vec("wdr_ready", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, ZERO);
    idle("wdr_after", ZERO);

    vec("rst_mw_enter", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MW);
    vec("rst_mw_hold",  5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MW);
    rst_vec("rst_mw_low", 1'b0, ZERO);
    rst_vec("rst_mw_low", 1'b0, ZERO);
    rst_vec("reboot_0", 1'b1, BOOT);
    for (int i = 1; i < 4; i++) idle("reboot_n", BOOT);
    idle("reboot_done", ZERO);

    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
